// File: rtl/avaliador_rodada.sv
// Round sequencer and judge: walks the round ROM, drives LEDs/servo preset,
// collects a character or sensor answer per round and keeps the hit score.
module avaliador_rodada #(
    parameter int N_RODADAS      = 8,
    parameter int TIMEOUT_CICLOS = 250000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        iniciar,
    input  logic [59:0] dado_rom,
    output logic [2:0]  endereco,
    input  logic [6:0]  rx_dado,
    input  logic        rx_pronto,
    input  logic [11:0] medida,
    input  logic        medida_pronto,
    output logic [3:0]  leds,
    output logic [1:0]  pos_servo,
    output logic        carrega_servo,
    output logic        habilita_sensor,
    output logic        acerto,
    output logic        erro,
    output logic [3:0]  acertos,
    output logic        fim,
    output logic [2:0]  estado_db
);

    localparam logic [2:0] OCIOSO    = 3'd0;
    localparam logic [2:0] CARREGA   = 3'd1;
    localparam logic [2:0] AGUARDA   = 3'd2;
    localparam logic [2:0] AVALIA    = 3'd3;
    localparam logic [2:0] RESULTADO = 3'd4;
    localparam logic [2:0] PROXIMA   = 3'd5;
    localparam logic [2:0] FIM       = 3'd6;

    localparam logic [1:0] OP_SENSOR  = 2'b11;
    localparam logic [6:0] CHAR_FECHA = 7'b0100011;
    localparam logic [2:0] ULTIMA     = 3'(N_RODADAS - 1);

    // T-1 always fits in clog2(T) bits, which is all the timer ever has to reach.
    localparam int         TW         = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0] TIMER_FIM = TW'(TIMEOUT_CICLOS - 1);

    logic [2:0]    estado;
    logic [1:0]    opcode;
    logic [3:0]    leds_r;
    logic [11:0]   lim_inf;
    logic [11:0]   lim_sup;
    logic [27:0]   esperado;
    logic [27:0]   buffer;
    logic [TW-1:0] timer;
    logic          marcado;
    logic          esgotado;

    logic rodada_char;
    logic evento_char;
    logic leitura_ok;
    logic estourou;
    logic acertou;

    assign rodada_char = (opcode != OP_SENSOR);
    assign evento_char = rodada_char && rx_pronto && (rx_dado == CHAR_FECHA);
    assign leitura_ok  = !rodada_char && medida_pronto &&
                         (medida >= lim_inf) && (medida <= lim_sup);
    assign estourou    = (timer == TIMER_FIM);
    // A timed-out character round is a miss even if the buffer happens to match.
    assign acertou     = rodada_char ? ((buffer == esperado) && !esgotado) : marcado;

    assign leds            = ((estado >= CARREGA) && (estado <= PROXIMA)) ? leds_r : 4'd0;
    assign habilita_sensor = (estado == AGUARDA) && (opcode == OP_SENSOR);
    assign estado_db       = estado;

    // NOTE: all state here is flop-based and updated with <= so every branch sees
    // the pre-edge values; the round fields are cleared on reset like any other flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado        <= OCIOSO;
            endereco      <= 3'd0;
            opcode        <= 2'd0;
            leds_r        <= 4'd0;
            lim_inf       <= 12'd0;
            lim_sup       <= 12'd0;
            esperado      <= 28'd0;
            buffer        <= 28'd0;
            timer         <= '0;
            marcado       <= 1'b0;
            esgotado      <= 1'b0;
            pos_servo     <= 2'd0;
            carrega_servo <= 1'b0;
            acerto        <= 1'b0;
            erro          <= 1'b0;
            acertos       <= 4'd0;
            fim           <= 1'b0;
        end else begin
            carrega_servo <= 1'b0;
            acerto        <= 1'b0;
            erro          <= 1'b0;

            case (estado)
                OCIOSO: begin
                    endereco <= 3'd0;
                    if (iniciar) begin
                        acertos <= 4'd0;
                        estado  <= CARREGA;
                    end
                end

                CARREGA: begin
                    opcode   <= dado_rom[59:58];
                    leds_r   <= dado_rom[57:54];
                    lim_inf  <= dado_rom[51:40];
                    lim_sup  <= dado_rom[39:28];
                    esperado <= dado_rom[27:0];
                    buffer   <= 28'd0;
                    timer    <= '0;
                    marcado  <= 1'b0;
                    esgotado <= 1'b0;
                    if ((dado_rom[59:58] == 2'b01) || (dado_rom[59:58] == 2'b10)) begin
                        pos_servo     <= dado_rom[53:52];
                        carrega_servo <= 1'b1;
                    end
                    estado <= AGUARDA;
                end

                AGUARDA: begin
                    timer <= timer + 1'b1;
                    if (rodada_char && rx_pronto)
                        buffer <= {buffer[20:0], rx_dado};
                    // Terminating events take priority over the timeout in the same cycle.
                    if (evento_char) begin
                        estado <= AVALIA;
                    end else if (leitura_ok) begin
                        marcado <= 1'b1;
                        estado  <= AVALIA;
                    end else if (estourou) begin
                        esgotado <= 1'b1;
                        estado   <= AVALIA;
                    end
                end

                AVALIA: begin
                    if (acertou) begin
                        acerto <= 1'b1;
                        if (acertos != 4'd15)
                            acertos <= acertos + 1'b1;
                    end else begin
                        erro <= 1'b1;
                    end
                    estado <= RESULTADO;
                end

                RESULTADO: estado <= PROXIMA;

                PROXIMA: begin
                    if (endereco == ULTIMA) begin
                        fim    <= 1'b1;
                        estado <= FIM;
                    end else begin
                        endereco <= endereco + 1'b1;
                        estado   <= CARREGA;
                    end
                end

                FIM: begin
                    if (iniciar) begin
                        fim      <= 1'b0;
                        endereco <= 3'd0;
                        acertos  <= 4'd0;
                        estado   <= CARREGA;
                    end
                end

                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_avaliador_rodada.sv
// Directed + randomized bench for avaliador_rodada with a per-round outcome model.
module tb_avaliador_rodada;

    localparam int T  = 20;
    localparam int NR = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        iniciar = 1'b0;
    logic [59:0] dado_rom;
    logic [2:0]  endereco;
    logic [6:0]  rx_dado = 7'd0;
    logic        rx_pronto = 1'b0;
    logic [11:0] medida = 12'd0;
    logic        medida_pronto = 1'b0;
    logic [3:0]  leds;
    logic [1:0]  pos_servo;
    logic        carrega_servo;
    logic        habilita_sensor;
    logic        acerto;
    logic        erro;
    logic [3:0]  acertos;
    logic        fim;
    logic [2:0]  estado_db;

    logic [59:0] rom [NR];
    assign dado_rom = rom[endereco];

    avaliador_rodada #(.N_RODADAS(NR), .TIMEOUT_CICLOS(T)) dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .dado_rom(dado_rom),
        .endereco(endereco), .rx_dado(rx_dado), .rx_pronto(rx_pronto),
        .medida(medida), .medida_pronto(medida_pronto), .leds(leds),
        .pos_servo(pos_servo), .carrega_servo(carrega_servo),
        .habilita_sensor(habilita_sensor), .acerto(acerto), .erro(erro),
        .acertos(acertos), .fim(fim), .estado_db(estado_db)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int model_hits = 0;

    int          ev_k[$];
    logic [11:0] ev_v[$];
    logic [6:0]  hist[$];

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        rx_pronto     = 1'b0;
        medida_pronto = 1'b0;
        iniciar       = 1'b0;
    endtask

    function automatic logic [59:0] w(input logic [1:0] op, input logic [3:0] l,
                                      input logic [1:0] p, input logic [11:0] lo,
                                      input logic [11:0] hi, input byte c0, input byte c1,
                                      input byte c2, input byte c3);
        return {op, l, p, lo, hi, c0[6:0], c1[6:0], c2[6:0], c3[6:0]};
    endfunction

    // Answer is right when the four most recent characters (zeros if fewer) spell the expected word.
    function automatic bit answer_matches(input logic [27:0] e);
        for (int j = 0; j < 4; j++) begin
            int idx = hist.size() - 4 + j;
            logic [6:0] c = (idx >= 0) ? hist[idx] : 7'd0;
            if (c != e[27-7*j -: 7]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic add_event(input int k, input logic [11:0] v);
        ev_k.push_back(k);
        ev_v.push_back(v);
    endtask

    // Queue the four expected characters of a ROM word with random gaps.
    task automatic add_answer(input logic [27:0] e, input int start);
        int k = start;
        for (int j = 0; j < 4; j++) begin
            k += $urandom_range(1, 3);
            add_event(k, {5'd0, e[27-7*j -: 7]});
        end
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        step();
        check("start_carrega", estado_db, 1);
        check("start_endereco", endereco, 0);
        check("start_acertos", acertos, 0);
        check("start_fim", fim, 0);
        model_hits = 0;
        step();
        check("start_aguarda", estado_db, 2);
    endtask

    // Entered on the first AGUARDA cycle of round r; leaves on its first AGUARDA cycle of r+1 (or in FIM).
    task automatic run_round(input int r);
        logic [59:0] word = rom[r];
        logic [1:0]  op = word[59:58];
        bit          is_char = (op != 2'b11);
        int          end_k = T;
        bit          hit = 1'b0;
        int          idx = 0;

        hist.delete();
        for (int i = 0; i < ev_k.size(); i++) begin
            if (ev_k[i] > T) break;
            if (is_char) begin
                hist.push_back(ev_v[i][6:0]);
                if (ev_v[i][6:0] == 7'h23) begin
                    end_k = ev_k[i];
                    hit = answer_matches(word[27:0]);
                    break;
                end
            end else if (ev_v[i] >= word[51:40] && ev_v[i] <= word[39:28]) begin
                end_k = ev_k[i];
                hit = 1'b1;
                break;
            end
        end

        check($sformatf("r%0d_endereco", r), endereco, r);
        check($sformatf("r%0d_leds", r), leds, word[57:54]);
        check($sformatf("r%0d_habilita", r), habilita_sensor, !is_char);
        check($sformatf("r%0d_carrega_servo", r), carrega_servo, (op == 2'b01 || op == 2'b10));
        if (op == 2'b01 || op == 2'b10)
            check($sformatf("r%0d_pos_servo", r), pos_servo, word[53:52]);

        for (int k = 1; k <= end_k; k++) begin
            if (k > 1) step();
            check($sformatf("r%0d_k%0d_aguarda", r, k), estado_db, 2);
            if (k == end_k)
                check($sformatf("r%0d_no_early_pulse", r), acerto | erro, 0);
            iniciar = (k == 2);
            if (idx < ev_k.size() && ev_k[idx] == k) begin
                if (is_char) begin
                    rx_pronto = 1'b1;
                    rx_dado   = ev_v[idx][6:0];
                end else begin
                    medida_pronto = 1'b1;
                    medida        = ev_v[idx];
                end
                idx++;
            end else if (k % 3 == 0) begin
                if (is_char) begin
                    medida_pronto = 1'b1;
                    medida        = 12'h075;
                end else begin
                    rx_pronto = 1'b1;
                    rx_dado   = 7'h23;
                end
            end
        end
        ev_k.delete();
        ev_v.delete();

        step();
        check($sformatf("r%0d_avalia", r), estado_db, 3);
        step();
        check($sformatf("r%0d_acerto", r), acerto, hit);
        check($sformatf("r%0d_erro", r), erro, !hit);
        if (hit && model_hits < 15) model_hits++;
        step();
        check($sformatf("r%0d_proxima", r), estado_db, 5);
        check($sformatf("r%0d_acertos", r), acertos, model_hits);
        step();
        if (r == NR - 1) begin
            check("fim_estado", estado_db, 6);
            check("fim_flag", fim, 1);
            check("fim_endereco", endereco, NR - 1);
        end else begin
            check($sformatf("r%0d_next_carrega", r), estado_db, 1);
            check($sformatf("r%0d_next_endereco", r), endereco, r + 1);
            step();
        end
    endtask

    initial begin
        rom[0] = w(2'b01, 4'b0010, 2'b11, 12'h000, 12'hFFF, "B", "$", "1", "#");
        rom[1] = w(2'b10, 4'b0101, 2'b01, 12'h000, 12'hFFF, "B", "$", "1", "#");
        rom[2] = w(2'b11, 4'b1000, 2'b10, 12'h070, 12'h080, 0, 0, 0, 0);
        rom[3] = w(2'b11, 4'b1001, 2'b00, 12'h070, 12'h080, 0, 0, 0, 0);
        rom[4] = w(2'b00, 4'b0001, 2'b10, 12'h000, 12'hFFF, "A", "7", "K", "#");
        rom[5] = w(2'b00, 4'b0011, 2'b01, 12'h000, 12'hFFF, "Z", "9", "Q", "#");
        rom[6] = w(2'b01, 4'b0110, 2'b10, 12'h000, 12'hFFF, "M", "2", "X", "#");
        rom[7] = w(2'b11, 4'b1111, 2'b11, 12'h123, 12'h456, 0, 0, 0, 0);

        step();
        step();
        check("reset_estado", estado_db, 0);
        check("reset_outputs", {endereco, leds, pos_servo, carrega_servo, habilita_sensor,
                                acerto, erro, acertos, fim}, 0);
        reset_n = 1'b1;
        step();
        step();
        check("idle_stays", estado_db, 0);
        check("idle_leds", leds, 0);

        // Game 1: directed scenarios, then two randomized rounds.
        start_game();
        add_event(2, "B"); add_event(4, "$"); add_event(5, "1"); add_event(7, "#");
        run_round(0);
        add_event(1, "C"); add_event(3, "$"); add_event(4, "1"); add_event(6, "#");
        run_round(1);
        add_event(3, 12'h065); add_event(6, 12'h080);
        run_round(2);
        add_event(2, 12'h081);
        run_round(3);
        run_round(4);
        add_event(5, "Z"); add_event(10, "9"); add_event(15, "Q"); add_event(20, "#");
        run_round(5);
        begin
            int k = 0;
            if ($urandom_range(0, 1) == 1) begin
                add_answer(rom[6][27:0], 0);
            end else begin
                int n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) begin
                    k += $urandom_range(1, 5);
                    add_event(k, {5'd0, 7'($urandom_range(65, 90))});
                end
                add_event(k + $urandom_range(1, 5), "#");
            end
        end
        run_round(6);
        begin
            int k = 0;
            for (int i = 0; i < 4; i++) begin
                k += $urandom_range(1, 6);
                add_event(k, 12'($urandom_range(12'h100, 12'h500)));
            end
        end
        run_round(7);

        step();
        step();
        check("fim_hold_estado", estado_db, 6);
        check("fim_hold_acertos", acertos, model_hits);
        check("fim_hold_endereco", endereco, NR - 1);

        // Game 2: every round answered correctly.
        start_game();
        for (int r = 0; r < NR; r++) begin
            if (rom[r][59:58] == 2'b11)
                add_event($urandom_range(1, 10),
                          rom[r][51:40] + 12'($urandom_range(0, rom[r][39:28] - rom[r][51:40])));
            else
                add_answer(rom[r][27:0], 0);
            run_round(r);
        end
        check("full_game_acertos", acertos, 8);

        // Game 3: reset in the middle of a round with two characters buffered.
        start_game();
        rx_pronto = 1'b1; rx_dado = "B";
        step();
        rx_pronto = 1'b1; rx_dado = "$";
        step();
        #2 reset_n = 1'b0;
        #1;
        check("abort_estado", estado_db, 0);
        check("abort_outputs", {endereco, leds, pos_servo, carrega_servo, habilita_sensor,
                                acerto, erro, acertos, fim}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_pulse", {acerto, erro}, 0);
        end
        reset_n = 1'b1;
        step();
        check("abort_idle", estado_db, 0);
        start_game();
        check("restart_endereco", endereco, 0);
        check("restart_carrega_servo", carrega_servo, 1);
        check("restart_pos_servo", pos_servo, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avaliador_rodada.md
Name: avaliador_rodada

Overview:
- Sequencer and judge that sits directly downstream of the round-definition ROM (3-bit address in, 60-bit round word out).
- Steps the ROM address through the rounds of a game and unpacks each round word.
- Drives the LEDs and servo preset, collects the player's answer from the serial character receiver or the distance sensor, and scores each round.
- Counts hits and flags end of game.

Parameters:
N_RODADAS, 8, number of rounds played (addresses 0..N_RODADAS-1, max 8)
TIMEOUT_CICLOS, 250000000, cycles allowed per round before automatic miss (>=2)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
iniciar  in  1  start/restart game (level sampled each cycle)
dado_rom  in  60  round word: opcode[59:58], leds[57:54], pos_inicial[53:52], lim_inf[51:40], lim_sup[39:28], expected[27:0]
endereco  out  3  ROM address of current round
rx_dado  in  7  received ASCII character
rx_pronto  in  1  one-cycle strobe, rx_dado valid
medida  in  12  sensor distance, 3 BCD digits
medida_pronto  in  1  one-cycle strobe, medida valid
leds  out  4  LED pattern of current round
pos_servo  out  2  servo initial position
carrega_servo  out  1  one-cycle pulse: load pos_servo into servo driver
habilita_sensor  out  1  high while waiting in a sensor round
acerto  out  1  one-cycle pulse: round hit
erro  out  1  one-cycle pulse: round miss
acertos  out  4  hit counter
fim  out  1  high after last round until restart
estado_db  out  3  state code for debug display

Behaviour:
- Reset (async, reset_n=0) forces state OCIOSO and clears all outputs, internal registers, timer and char buffer to 0.
- FSM states and codes: OCIOSO=0, CARREGA=1, AGUARDA=2, AVALIA=3, RESULTADO=4, PROXIMA=5, FIM=6. estado_db equals the code. Codes 7 and unused go to OCIOSO.
- OCIOSO:
  - endereco=0, leds=0.
  - On iniciar=1: clear acertos, go CARREGA.
- CARREGA (1 cycle):
  - Register all dado_rom fields.
  - Clear the 28-bit char buffer and the timer.
  - If opcode is 01 or 10: pos_servo<=pos_inicial and pulse carrega_servo on the following cycle.
  - Go AGUARDA.
- leds output equals the registered leds field in states CARREGA..PROXIMA, and is 0 otherwise.
- AGUARDA, opcode 00/01/10 (character round):
  - On rx_pronto: buffer <= {buffer[20:0], rx_dado}. The first char of a 4-char answer ends in [27:21].
  - If rx_dado == 7'b0100011 ('#'): go AVALIA.
  - Chars beyond 4 shift older ones out; only '#' terminates.
  - medida_pronto is ignored.
- AGUARDA, opcode 11 (sensor round):
  - habilita_sensor=1; rx_pronto is ignored.
  - On medida_pronto: if lim_inf <= medida <= lim_sup (unsigned 12-bit compare, valid for BCD), mark hit and go AVALIA.
  - Out-of-range readings are ignored and the round keeps waiting.
- Timeout:
  - Timer increments every AGUARDA cycle.
  - When timer == TIMEOUT_CICLOS-1 with no terminating event, mark miss and go AVALIA.
  - If a terminating event ('#' or in-range medida) occurs in the same cycle as timeout, the event wins.
- AVALIA (1 cycle):
  - Character round: hit iff buffer == expected (full 28 bits).
  - Sensor round: hit as marked.
  - Go RESULTADO.
- RESULTADO (1 cycle):
  - Pulse acerto or erro (exactly one).
  - On hit, acertos increments, saturating at 15.
- PROXIMA (1 cycle):
  - If endereco == N_RODADAS-1: go FIM.
  - Else endereco+1, go CARREGA.
- FIM:
  - fim=1; endereco and acertos are held.
  - On iniciar=1: fim=0, endereco=0, acertos=0, go CARREGA.
- iniciar is ignored in all states except OCIOSO and FIM.
- Latency:
  - '#' strobe in cycle t (sampled at edge t) gives AVALIA in t+1 and the acerto/erro pulse in t+2.
  - Next round's CARREGA in t+4.
- Asserting reset_n=0 in the middle of any state aborts immediately to OCIOSO with all outputs 0. No pulse is emitted.

Test Plan:
- ROM word B$1# (opcode 01, leds 0010, pos 11); iniciar; send 'B','$','1','#' -> carrega_servo pulse with pos_servo=3, leds=0010, acerto pulse 2 cycles after '#', acertos=1, endereco=1.
- Same round, send 'C','$','1','#' -> erro pulse, acertos unchanged, advance to next round.
- Sensor round (lim_inf 0x070, lim_sup 0x080): medida 0x065 then 0x080 -> habilita_sensor=1, first ignored, second gives acerto. A repeat with 0x081 only -> erro after timeout.
- TIMEOUT_CICLOS=20, no input -> erro exactly 20 AGUARDA cycles after entry. '#' on cycle 20 -> evaluated, not timeout.
- Full game with N_RODADAS=8, all answers correct -> acertos=8, fim=1 after round 7, endereco=7. iniciar in FIM -> restart with acertos=0, endereco=0.
- reset_n low during AGUARDA with 2 chars buffered -> immediate OCIOSO, all outputs 0, no acerto/erro pulse. Reset release + iniciar starts at address 0.
